turn_sequencer: RTL and testbench

- Sequences the combinational segment verifier through one player turn of the Simon Says game.
- The game FSM launches it with `start` and a round length. It then:
  - walks `check_round` from 0 to round length − 1,
  - captures one button press per step and presents it to the verifier,
  - reports pass, fail or timeout back to the game FSM.
- It owns press/release edge handling and the per-press timeout so the verifier stays purely combinational.

---
 rtl/simon_pkg.sv | 18 +
 rtl/turn_timer.sv | 26 ++
 rtl/turn_sequencer.sv | 131 +++++++++++++
 tb/tb_turn_sequencer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared types and sizing for the Simon Says game blocks.
package simon_pkg;

    localparam int MAX_LEN = 33;
    localparam int IDX_W   = 6;

    typedef logic [1:0] seg_t;

    typedef enum logic [2:0] {
        IDLE,
        RELEASE,
        PRESS,
        CHECK,
        PASS,
        FAIL
    } turn_state_t;

endpackage

// File: rtl/turn_timer.sv
// Clearable up-counter that flags when LIMIT cycles have elapsed.
// Also intended for pacing the display playback.
module turn_timer #(
    parameter int CNT_W = 26,
    parameter int LIMIT = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] count;

    // Clear has priority so a state change can restart the wait in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       count <= '0;
        else if (clear)  count <= '0;
        else if (enable) count <= count + 1'b1;
    end

    // Count sits at LIMIT-1 on the cycle the LIMIT-th increment would occur.
    assign expired = (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/turn_sequencer.sv
// Walks the segment verifier through one player turn: waits for release,
// captures a press, checks it, and reports pass / fail / timeout.
module turn_sequencer #(
    parameter int MAX_LEN        = simon_pkg::MAX_LEN,
    parameter int IDX_W          = simon_pkg::IDX_W,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int CNT_W          = 26
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [IDX_W-1:0] round_len,
    input  logic [3:0]       buttons,
    input  logic             result,
    output logic [IDX_W-1:0] check_round,
    output logic [3:0]       press_out,
    output logic             busy,
    output logic             turn_pass,
    output logic             turn_fail,
    output logic             timed_out
);

    import simon_pkg::*;

    localparam logic [IDX_W-1:0] MAX_LEN_I = IDX_W'(MAX_LEN);

    turn_state_t      state, state_n;
    logic [IDX_W-1:0] len_q, len_n, round_n, len_clamp;
    logic [3:0]       press_n;
    logic             timeout_n, timer_clr, timer_en, expired, last;

    assign len_clamp = (round_len > MAX_LEN_I) ? MAX_LEN_I : round_len;
    assign last      = (check_round == len_q - 1'b1);

    turn_timer #(
        .CNT_W (CNT_W),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clr),
        .enable  (timer_en),
        .expired (expired)
    );

    // Next-state, datapath and timer control; events beat a same-cycle timeout.
    always_comb begin
        state_n   = state;
        len_n     = len_q;
        round_n   = check_round;
        press_n   = press_out;
        timeout_n = 1'b0;
        timer_clr = 1'b0;
        timer_en  = 1'b0;
        case (state)
            IDLE: begin
                timer_clr = 1'b1;
                if (start) begin
                    len_n   = len_clamp;
                    round_n = '0;
                    // A held button must be released before it can count.
                    state_n = (len_clamp == '0) ? PASS : RELEASE;
                end
            end
            RELEASE: begin
                if (buttons == 4'b0) begin
                    timer_clr = 1'b1;
                    state_n   = PRESS;
                end else if (expired) begin
                    timeout_n = 1'b1;
                    state_n   = FAIL;
                end else begin
                    timer_en = 1'b1;
                end
            end
            PRESS: begin
                if (buttons != 4'b0) begin
                    // Raw value: multi-button presses go to the verifier as-is.
                    press_n = buttons;
                    state_n = CHECK;
                end else if (expired) begin
                    timeout_n = 1'b1;
                    state_n   = FAIL;
                end else begin
                    timer_en = 1'b1;
                end
            end
            CHECK: begin
                if (!result) begin
                    state_n = FAIL;
                end else if (last) begin
                    state_n = PASS;
                end else begin
                    round_n   = check_round + 1'b1;
                    timer_clr = 1'b1;
                    state_n   = RELEASE;
                end
            end
            PASS: begin
                press_n = '0;
                state_n = IDLE;
            end
            FAIL:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs; pulses are decoded from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            len_q       <= '0;
            check_round <= '0;
            press_out   <= '0;
            busy        <= 1'b0;
            turn_pass   <= 1'b0;
            turn_fail   <= 1'b0;
            timed_out   <= 1'b0;
        end else begin
            state       <= state_n;
            len_q       <= len_n;
            check_round <= round_n;
            press_out   <= press_n;
            busy        <= (state_n != IDLE);
            turn_pass   <= (state_n == PASS);
            turn_fail   <= (state_n == FAIL);
            timed_out   <= timeout_n;
        end
    end

endmodule

// File: tb/tb_turn_sequencer.sv
// Directed bench for turn_sequencer with a behavioural segment verifier.
module tb_turn_sequencer;

    import simon_pkg::*;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset, start, result;
    logic [5:0] round_len, check_round;
    logic [3:0] buttons, press_out;
    logic       busy, turn_pass, turn_fail, timed_out;

    seg_t segment [MAX_LEN];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    // Verifier: match only when press is the one-hot code of the segment colour.
    always_comb begin
        result = 1'b0;
        if (int'(check_round) < MAX_LEN)
            result = (press_out == (4'b0001 << segment[check_round]));
    end

    turn_sequencer #(
        .MAX_LEN        (MAX_LEN),
        .IDX_W          (6),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .round_len   (round_len),
        .buttons     (buttons),
        .result      (result),
        .check_round (check_round),
        .press_out   (press_out),
        .busy        (busy),
        .turn_pass   (turn_pass),
        .turn_fail   (turn_fail),
        .timed_out   (timed_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_start(input int len);
        round_len = 6'(len);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // From RELEASE: release, press b, check the CHECK cycle, step past it.
    task automatic do_press(input logic [3:0] b, input int idx, input string tag);
        buttons = 4'b0;
        tick();
        buttons = b;
        tick();
        chk({tag, "_press"}, 32'(press_out), 32'(b));
        chk({tag, "_round"}, 32'(check_round), idx);
        tick();
    endtask

    initial begin
        for (int i = 0; i < MAX_LEN; i++) segment[i] = seg_t'(i % 4);
        reset = 1'b1; start = 1'b0; round_len = '0; buttons = '0;
        tick(); tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_round", 32'(check_round), 0);
        chk("rst_press", 32'(press_out), 0);
        chk("rst_pass", 32'(turn_pass), 0);
        chk("rst_fail", 32'(turn_fail), 0);
        chk("rst_tmo", 32'(timed_out), 0);
        reset = 1'b0;
        tick();

        // 1: three correct presses
        do_start(3);
        chk("t1_busy", 32'(busy), 1);
        do_press(4'b0001, 0, "t1a");
        chk("t1_nopass", 32'(turn_pass), 0);
        do_press(4'b0010, 1, "t1b");
        do_press(4'b0100, 2, "t1c");
        chk("t1_pass", 32'(turn_pass), 1);
        chk("t1_fail", 32'(turn_fail), 0);
        chk("t1_tmo", 32'(timed_out), 0);
        tick();
        chk("t1_pass_end", 32'(turn_pass), 0);
        chk("t1_busy_end", 32'(busy), 0);
        chk("t1_press_clr", 32'(press_out), 0);

        // 2: wrong colour on second entry
        do_start(2);
        do_press(4'b0001, 0, "t2a");
        do_press(4'b1000, 1, "t2b");
        chk("t2_fail", 32'(turn_fail), 1);
        chk("t2_tmo", 32'(timed_out), 0);
        tick();
        chk("t2_busy_end", 32'(busy), 0);
        chk("t2_fail_end", 32'(turn_fail), 0);

        // 3: two buttons at once
        do_start(1);
        do_press(4'b0011, 0, "t3");
        chk("t3_fail", 32'(turn_fail), 1);
        chk("t3_tmo", 32'(timed_out), 0);
        tick();

        // 4: no press -> timeout 16 cycles after entering PRESS
        buttons = 4'b0;
        do_start(1);
        tick();
        repeat (TO - 1) tick();
        chk("t4_early", 32'(turn_fail), 0);
        chk("t4_busy", 32'(busy), 1);
        tick();
        chk("t4_fail", 32'(turn_fail), 1);
        chk("t4_tmo", 32'(timed_out), 1);
        tick();
        chk("t4_busy_end", 32'(busy), 0);
        chk("t4_fail_end", 32'(turn_fail), 0);

        // 4b: button never released -> timeout from RELEASE
        buttons = 4'b0010;
        do_start(1);
        repeat (TO - 1) tick();
        chk("t4b_early", 32'(turn_fail), 0);
        tick();
        chk("t4b_fail", 32'(turn_fail), 1);
        chk("t4b_tmo", 32'(timed_out), 1);
        tick();
        buttons = 4'b0;

        // 5: button held across start, extra start while busy ignored
        buttons = 4'b0001;
        do_start(1);
        repeat (3) tick();
        chk("t5_held_pass", 32'(turn_pass), 0);
        chk("t5_held_fail", 32'(turn_fail), 0);
        chk("t5_held_busy", 32'(busy), 1);
        round_len = 6'd5;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        chk("t5_restart_busy", 32'(busy), 1);
        do_press(4'b0001, 0, "t5");
        chk("t5_pass", 32'(turn_pass), 1);
        tick();

        // 6: async reset in CHECK at entry 5, then zero-length turn
        do_start(6);
        for (int i = 0; i < 5; i++) do_press(4'(1 << (i % 4)), i, "t6");
        buttons = 4'b0;
        tick();
        buttons = 4'b0010;
        tick();
        chk("t6_round5", 32'(check_round), 5);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_round", 32'(check_round), 0);
        chk("t6_rst_press", 32'(press_out), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_fail", 32'(turn_fail), 0);
        tick();
        reset   = 1'b0;
        buttons = 4'b0;
        tick();
        do_start(0);
        chk("t6_len0_pass", 32'(turn_pass), 1);
        chk("t6_len0_busy", 32'(busy), 1);
        tick();
        chk("t6_len0_end", 32'(turn_pass), 0);
        chk("t6_len0_idle", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
